weight_bram_arbiter: RTL and testbench
======================================

// Module: weight_bram_arbiter
// PURPOSE
//  Shares one read-only weight BRAM between N_REQ layer weight loaders. Each loader requests a burst
//  (base address + word count); the arbiter grants one requester at a time and drives the BRAM port.
//  It returns each data word with the requester ID, honouring the BRAM's fixed read latency.
//  Sits between the per-layer loaders and the single BRAM instance in the inference datapath.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8)
//  W          8   BRAM data width (bits)
//  ADDR_WIDTH 15  BRAM address width
//  LEN_WIDTH  16  burst length field width (words)
//  RD_LAT     2   BRAM cycles from addr/ren to valid dout (1..4)
// PORTS
//  clk        in   1                  system clock, rising edge
//  rst_n      in   1                  asynchronous active-low reset
//  req        in   N_REQ              per-requester burst request, level; held until own done
//  base_addr  in   N_REQ*ADDR_WIDTH   flattened start addresses, slice i = requester i
//  burst_len  in   N_REQ*LEN_WIDTH    flattened burst lengths in words, sampled at grant
//  grant      out  N_REQ              one-hot, high for the whole owned burst
//  done       out  N_REQ              one-cycle pulse to the requester whose burst finished
//  rd_valid   out  1                  rd_data valid this cycle
//  rd_data    out  W                  BRAM word (bram_dout passthrough, qualified by rd_valid)
//  rd_id      out  $clog2(N_REQ)      owner of rd_data
//  bram_en    out  1                  BRAM enable
//  bram_ren   out  1                  BRAM read enable
//  bram_addr  out  ADDR_WIDTH         BRAM address
//  bram_dout  in   W                  BRAM read data
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; grant, done, rd_valid, bram_en, bram_ren = 0; bram_addr = 0;
//    rd_id = 0; RR pointer = N_REQ-1 (so requester 0 wins first); in-flight data discarded.
//  - FSM: IDLE -> ISSUE -> DRAIN -> IDLE.
//  - IDLE: if any req, pick winner (round robin: first set req after last winner, wrapping),
//    register grant, latch base/len, bram_addr<=base, bram_en=bram_ren<=1, go ISSUE. If len==0:
//    no BRAM access, go DRAIN directly with empty pipeline.
//  - ISSUE: one address per cycle; after the len-th address deassert bram_ren, go DRAIN.
//    Address increments mod 2^ADDR_WIDTH (wrap, no error).
//  - Valid pipeline: RD_LAT-deep shift of (valid,id); rd_valid high exactly RD_LAT cycles after each
//    issued address. Words delivered in address order, no gaps.
//  - DRAIN: wait until pipeline empty; done[winner] pulses in the cycle of the last rd_valid
//    (len==0: one cycle after grant). Grant drops and bram_en=0 the cycle after done; return to IDLE.
//  - Timing: req seen cycle 0 -> grant+first addr cycle 1 -> first rd_valid cycle 1+RD_LAT ->
//    last rd_valid/done cycle len+RD_LAT. Min one IDLE cycle between bursts.
//  - req dropped mid-burst: burst still completes (no abort). req of non-owners ignored until IDLE.
//  - base_addr/burst_len changes after grant are ignored (latched).
//  - Simultaneous requests: exactly one grant; losers wait; no requester starves (RR).
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, RR pointer unused (starvation
//    possible). Undefined (default): round-robin as above.
// TESTING
//  1 Single: req[0], base=0x0010, len=4 -> grant[0] at c1, bram_addr 0x10..0x13 c1..c4,
//    rd_valid c3..c6 with rd_id=0, done[0] c6, grant low c7.
//  2 Contention: req=4'b1111 all len=2 -> grants in order 0,1,2,3; repeat with RR pointer at 1
//    -> order 2,3,0,1; ARB_FIXED_PRIO_EN build -> 0 always first.
//  3 Wrap: base=0x7FFE, len=4 -> addresses 0x7FFE,0x7FFF,0x0000,0x0001; 4 valid words.
//  4 Zero length: req[2], len=0 -> grant[2] c1, no bram_ren, done[2] c2, no rd_valid.
//  5 Reset mid-burst: len=8, rst_n low at c4 -> all outputs 0 immediately, no further rd_valid;
//    after release same req restarts burst from base.
//  6 Drop req mid-burst: req[1] low at c3 of len=6 -> all 6 words and done[1] still delivered.

Source files
------------

// File: rtl/weight_bram_arbiter.sv
// ---------------------------------------------------------------------------
// weight_bram_arbiter
//   Shares one read-only weight BRAM between N_REQ layer weight loaders.
//   A loader raises req with a base address and word count. The arbiter grants
//   one loader at a time and streams its burst out of the BRAM. Each returned
//   word is tagged with the owner ID. The BRAM's fixed read latency is honoured.
//
//   Build option: define ARB_FIXED_PRIO_EN to get fixed priority, where the
//   lowest index wins. The default build uses round robin.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req          per-requester burst request, level, held until own done
//   base_addr    flattened start addresses, slice i belongs to requester i
//   burst_len    flattened burst lengths in words, sampled at grant
//   grant        one-hot owner of the BRAM for the whole burst
//   done         one-cycle pulse in the cycle of the owner's last word
//   rd_valid     rd_data carries a word this cycle
//   rd_data      BRAM word, bram_dout passthrough
//   rd_id        owner of rd_data
//   bram_en      BRAM enable
//   bram_ren     BRAM read enable
//   bram_addr    BRAM address
//   bram_dout    BRAM read data
// ---------------------------------------------------------------------------
module weight_bram_arbiter #(
    parameter int N_REQ      = 4,
    parameter int W          = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int LEN_WIDTH  = 16,
    parameter int RD_LAT     = 2,
    localparam int IDW       = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] base_addr,
    input  logic [N_REQ*LEN_WIDTH-1:0]  burst_len,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ-1:0]            done,
    output logic                        rd_valid,
    output logic [W-1:0]                rd_data,
    output logic [IDW-1:0]              rd_id,
    output logic                        bram_en,
    output logic                        bram_ren,
    output logic [ADDR_WIDTH-1:0]       bram_addr,
    input  logic [W-1:0]                bram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Pattern of a pipeline holding only the final word in its last stage.
    localparam logic [RD_LAT-1:0] LAST_ONLY = RD_LAT'(1'b1) << (RD_LAT - 1);

    state_t                  state_r, state_s;
    logic [N_REQ-1:0]        grant_r, grant_s;
    logic [N_REQ-1:0]        done_r, done_s;
    logic                    en_r, en_s;
    logic                    ren_r, ren_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [LEN_WIDTH-1:0]    cnt_r, cnt_s;
    logic [IDW-1:0]          owner_r, owner_s;
    logic [IDW-1:0]          last_r, last_s;
    logic [RD_LAT-1:0]       vpipe_r, vpipe_s;
    logic [IDW-1:0]          idpipe_r [RD_LAT];
    logic [IDW-1:0]          idpipe_s [RD_LAT];
    logic [IDW-1:0]          winner_s;
    logic [ADDR_WIDTH-1:0]   win_base_s;
    logic [LEN_WIDTH-1:0]    win_len_s;

    // Winner selection. Round robin scans from the slot after the last winner,
    // wrapping around. The nearest set request wins, so it is assigned last.
    function automatic logic [IDW-1:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDW-1:0]   last);
        logic [IDW-1:0] p;
        int             j;
        p = last;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) begin
                p = IDW'(i);
            end else begin
                p = p;
            end
        end
`else
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(last) + k) % N_REQ;
            if (r[j]) begin
                p = IDW'(j);
            end else begin
                p = p;
            end
        end
`endif
        return p;
    endfunction

    assign winner_s   = pick(req, last_r);
    assign win_base_s = base_addr[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
    assign win_len_s  = burst_len[winner_s*LEN_WIDTH +: LEN_WIDTH];

    // Next-state, BRAM issue, valid pipeline and done generation.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        en_s    = en_r;
        ren_s   = ren_r;
        addr_s  = addr_r;
        cnt_s   = cnt_r;
        owner_s = owner_r;
        last_s  = last_r;
        done_s  = '0;

        // Each issued read becomes valid RD_LAT cycles later.
        vpipe_s[0]  = ren_r;
        idpipe_s[0] = owner_r;
        for (int k = 1; k < RD_LAT; k++) begin
            vpipe_s[k]  = vpipe_r[k-1];
            idpipe_s[k] = idpipe_r[k-1];
        end

        case (state_r)
            IDLE: begin
                if (|req) begin
                    grant_s = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
                    owner_s = winner_s;
                    last_s  = winner_s;
                    cnt_s   = win_len_s;
                    if (win_len_s != {LEN_WIDTH{1'b0}}) begin
                        addr_s  = win_base_s;
                        en_s    = 1'b1;
                        ren_s   = 1'b1;
                        state_s = ISSUE;
                    end else begin
                        state_s = DRAIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (cnt_r <= LEN_WIDTH'(1)) begin
                    ren_s   = 1'b0;
                    state_s = DRAIN;
                end else begin
                    addr_s = addr_r + ADDR_WIDTH'(1);
                    cnt_s  = cnt_r - LEN_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (|done_r) begin
                    grant_s = '0;
                    en_s    = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                grant_s = '0;
                en_s    = 1'b0;
                ren_s   = 1'b0;
                state_s = IDLE;
            end
        endcase

        // Done is registered so that it coincides with the final rd_valid.
        // It fires when no more reads will be issued and the next pipeline
        // holds only that final word. For a zero-length burst the pipeline is
        // empty, so done fires one cycle after grant.
        if ((state_r != IDLE) && (done_r == '0) && !ren_s &&
            ((vpipe_s == LAST_ONLY) || (vpipe_s == '0))) begin
            done_s = grant_r;
        end else begin
            done_s = '0;
        end
    end

    // State and output registers; reset discards any in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= '0;
            done_r  <= '0;
            en_r    <= 1'b0;
            ren_r   <= 1'b0;
            addr_r  <= '0;
            cnt_r   <= '0;
            owner_r <= '0;
            last_r  <= IDW'(N_REQ - 1);
            vpipe_r <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                idpipe_r[k] <= '0;
            end
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            done_r  <= done_s;
            en_r    <= en_s;
            ren_r   <= ren_s;
            addr_r  <= addr_s;
            cnt_r   <= cnt_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            vpipe_r <= vpipe_s;
            for (int k = 0; k < RD_LAT; k++) begin
                idpipe_r[k] <= idpipe_s[k];
            end
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign bram_en   = en_r;
    assign bram_ren  = ren_r;
    assign bram_addr = addr_r;
    assign rd_valid  = vpipe_r[RD_LAT-1];
    assign rd_id     = idpipe_r[RD_LAT-1];
    assign rd_data   = bram_dout;

endmodule

// File: tb/tb_weight_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_weight_bram_arbiter
//   Bench for weight_bram_arbiter. A behavioural BRAM with RD_LAT latency
//   returns an address-derived pattern. Expected words are queued when a burst
//   is requested and are popped as rd_valid words arrive. Single bursts are
//   table-driven. Contention, reset mid-burst and req drop are hand sequences.
// ---------------------------------------------------------------------------
module tb_weight_bram_arbiter;

    localparam int N_REQ  = 4;
    localparam int W      = 8;
    localparam int AW     = 15;
    localparam int LW     = 16;
    localparam int RD_LAT = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [N_REQ*AW-1:0] base_addr;
    logic [N_REQ*LW-1:0] burst_len;
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    done;
    logic                rd_valid;
    logic [W-1:0]        rd_data;
    logic [1:0]          rd_id;
    logic                bram_en;
    logic                bram_ren;
    logic [AW-1:0]       bram_addr;
    logic [W-1:0]        bram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int          idx;
        logic [14:0] base;
        logic [15:0] len;
        int          exp_done;
        int          exp_nv;
    } vec_t;
    vec_t tbl[5];

    weight_bram_arbiter #(
        .N_REQ(N_REQ), .W(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_addr),
        .burst_len(burst_len), .grant(grant), .done(done), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_id(rd_id), .bram_en(bram_en), .bram_ren(bram_ren),
        .bram_addr(bram_addr), .bram_dout(bram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: the word for an address appears RD_LAT cycles later.
    function automatic logic [7:0] f(input logic [14:0] a);
        return a[7:0] ^ {a[14:8], 1'b0} ^ 8'h5A;
    endfunction

    logic [AW-1:0] ba_pipe [RD_LAT];
    always @(posedge clk) begin
        ba_pipe[0] <= bram_addr;
        for (int k = 1; k < RD_LAT; k++) ba_pipe[k] <= ba_pipe[k-1];
    end
    assign bram_dout = f(ba_pipe[RD_LAT-1]);

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Advance to the next falling edge and score any delivered word.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (rd_valid) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d data=%02h, required no word",
                         rd_id, rd_data);
            end else begin
                e = sbq.pop_front();
                if (rd_id !== e.id || rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_word: got id=%0d data=%02h required id=%0d data=%02h",
                             rd_id, rd_data, e.id, e.data);
                end
            end
        end
    endtask

    task automatic push_burst(input int idx, input logic [14:0] base, input int len);
        sb_t e;
        for (int i = 0; i < len; i++) begin
            e.id   = 2'(idx);
            e.data = f(base + 15'(i));
            sbq.push_back(e);
        end
    endtask

    // Request one burst and observe it to completion. Cycle numbers are
    // relative to the cycle in which req is raised (cycle 0).
    task automatic run_burst(input int idx, input logic [14:0] base, input logic [15:0] len,
                             input int drop_at, output int g_c, output int d_c,
                             output int low_c, output int nv, output int nren,
                             output int aerr);
        int          c0;
        int          rel;
        logic [14:0] a;
        g_c = -1; d_c = -1; low_c = -1; nv = 0; nren = 0; aerr = 0;
        base_addr[idx*AW +: AW] = base;
        burst_len[idx*LW +: LW] = len;
        req[idx] = 1'b1;
        c0 = cyc;
        push_burst(idx, base, int'(len));
        for (int t = 0; t < 80 && low_c < 0; t++) begin
            tick();
            rel = cyc - c0;
            if (grant == (4'b1 << idx) && g_c < 0) g_c = rel;
            if (rd_valid) nv++;
            if (bram_ren) nren++;
            if (rel >= 1 && rel <= int'(len)) begin
                a = base + 15'(rel - 1);
                if (!(bram_ren && bram_addr == a)) aerr++;
            end
            if (d_c >= 0 && grant == 4'b0 && low_c < 0) low_c = rel;
            if (done == (4'b1 << idx) && d_c < 0) begin
                d_c = rel;
                req[idx] = 1'b0;
            end
            if (drop_at > 0 && rel == 2) begin
                base_addr[idx*AW +: AW] = 15'h5555;
                burst_len[idx*LW +: LW] = 16'd3;
            end
            if (drop_at > 0 && rel == drop_at) req[idx] = 1'b0;
        end
        req[idx] = 1'b0;
    endtask

    task automatic contention(input int e0, input int e1, input int e2, input int e3,
                              input string tag);
        int exp_ord[4];
        int ord[4];
        int n;
        int bad;
        exp_ord = '{e0, e1, e2, e3};
        n = 0; bad = 0;
        ord = '{-1, -1, -1, -1};
        for (int i = 0; i < 4; i++) begin
            base_addr[i*AW +: AW] = 15'h0400 + 15'(i * 16);
            burst_len[i*LW +: LW] = 16'd2;
        end
        for (int i = 0; i < 4; i++) push_burst(exp_ord[i], 15'h0400 + 15'(exp_ord[i] * 16), 2);
        req = 4'hF;
        for (int t = 0; t < 200 && n < 4; t++) begin
            tick();
            if ($countones(grant) > 1) bad++;
            if ($countones(done) > 1) bad++;
            for (int i = 0; i < 4; i++) begin
                if (done[i] && n < 4) begin
                    ord[n] = i;
                    n++;
                    req[i] = 1'b0;
                end
            end
        end
        req = 4'h0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) chk($sformatf("%s_order%0d", tag, i), ord[i], exp_ord[i]);
        chk({tag, "_onehot"}, bad, 0);
        chk({tag, "_sb_empty"}, sbq.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_valid"}, int'(rd_valid), 0);
        chk({tag, "_bram_en"}, int'(bram_en), 0);
        chk({tag, "_bram_ren"}, int'(bram_ren), 0);
        chk({tag, "_bram_addr"}, int'(bram_addr), 0);
        chk({tag, "_rd_id"}, int'(rd_id), 0);
    endtask

    initial begin
        int g_c, d_c, low_c, nv, nren, aerr;

        tbl[0] = '{idx: 0, base: 15'h0010, len: 16'd4, exp_done: 6, exp_nv: 4};
        tbl[1] = '{idx: 2, base: 15'h0000, len: 16'd0, exp_done: 2, exp_nv: 0};
        tbl[2] = '{idx: 1, base: 15'h7FFE, len: 16'd4, exp_done: 6, exp_nv: 4};
        tbl[3] = '{idx: 3, base: 15'h1234, len: 16'd1, exp_done: 3, exp_nv: 1};
        tbl[4] = '{idx: 1, base: 15'h0100, len: 16'd6, exp_done: 8, exp_nv: 6};

        rst_n = 1'b0;
        req = '0;
        base_addr = '0;
        burst_len = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fresh pointer: requester 0 wins first.
        contention(0, 1, 2, 3, "rr_a");

        for (int v = 0; v < 5; v++) begin
            run_burst(tbl[v].idx, tbl[v].base, tbl[v].len, 0, g_c, d_c, low_c, nv, nren, aerr);
            chk($sformatf("v%0d_grant_cycle", v), g_c, 1);
            chk($sformatf("v%0d_done_cycle", v), d_c, tbl[v].exp_done);
            chk($sformatf("v%0d_grant_low", v), low_c, tbl[v].exp_done + 1);
            chk($sformatf("v%0d_nvalid", v), nv, tbl[v].exp_nv);
            chk($sformatf("v%0d_nren", v), nren, int'(tbl[v].len));
            chk($sformatf("v%0d_addr_seq", v), aerr, 0);
            chk($sformatf("v%0d_sb_empty", v), sbq.size(), 0);
        end

        // Last winner was 1.
`ifdef ARB_FIXED_PRIO_EN
        contention(0, 1, 2, 3, "rr_b");
`else
        contention(2, 3, 0, 1, "rr_b");
`endif

        // Reset in cycle 4 of an 8-word burst; only the words for base and
        // base+1 arrive before the reset.
        base_addr[0 +: AW] = 15'h0200;
        burst_len[0 +: LW] = 16'd8;
        push_burst(0, 15'h0200, 2);
        req[0] = 1'b1;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        chk("midrst_sb_empty", sbq.size(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        run_burst(0, 15'h0200, 16'd8, 0, g_c, d_c, low_c, nv, nren, aerr);
        chk("restart_grant_cycle", g_c, 1);
        chk("restart_done_cycle", d_c, 10);
        chk("restart_nvalid", nv, 8);
        chk("restart_addr_seq", aerr, 0);
        chk("restart_sb_empty", sbq.size(), 0);

        // req dropped in cycle 3; base/len are rewritten after the grant.
        run_burst(1, 15'h0300, 16'd6, 3, g_c, d_c, low_c, nv, nren, aerr);
        chk("drop_grant_cycle", g_c, 1);
        chk("drop_done_cycle", d_c, 8);
        chk("drop_grant_low", low_c, 9);
        chk("drop_nvalid", nv, 6);
        chk("drop_addr_seq", aerr, 0);
        chk("drop_sb_empty", sbq.size(), 0);

        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
